// File: rtl/register_file_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_2r1w
//  Description : 32 x 32-bit general-purpose register file with two
//                combinational read ports and one clocked write port.
//                Register 0 is hardwired to zero. Asynchronous active-high
//                reset clears every register.
//                Optional macro REGFILE_WRITE_BYPASS_EN forwards the pending
//                write data to any read port addressing the write target.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_2r1w #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    output logic [DATA_WIDTH-1:0] r1_data,
    input  logic [ADDR_WIDTH-1:0] r2_addr,
    output logic [DATA_WIDTH-1:0] r2_data,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  reg_write
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    // Flattened view of the storage; entry 0 is a constant zero.
    logic [DATA_WIDTH-1:0] w_mem [c_DEPTH];

    // A write to address 0 is discarded here so entry 0 never needs a flop.
    // An X on reg_write evaluates false in the entry enables below.
    logic w_wr_en;
    assign w_wr_en = reg_write && (wr_addr != '0);

    generate
        for (genvar i = 0; i < c_DEPTH; i++) begin : g_regs
            if (i == 0) begin : g_zero
                assign w_mem[i] = '0;
            end else begin : g_entry
                logic [DATA_WIDTH-1:0] r_q;

                // Capture the write-back when this entry is addressed; reset clears it at once.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_q <= '0;
                    end else if (w_wr_en && (wr_addr == ADDR_WIDTH'(i))) begin
                        r_q <= wr_data;
                    end
                end

                assign w_mem[i] = r_q;
            end
        end
    endgenerate

    // Per-port forwarding select: only asserted when the bypass build is chosen.
    logic w_byp1;
    logic w_byp2;

`ifdef REGFILE_WRITE_BYPASS_EN
    // w_wr_en already excludes address 0, so register 0 still reads zero.
    assign w_byp1 = w_wr_en && !reset && (r1_addr == wr_addr);
    assign w_byp2 = w_wr_en && !reset && (r2_addr == wr_addr);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    // Read port 1: combinational from storage, optionally forwarded.
    always_comb begin
        r1_data = w_mem[r1_addr];
        if (w_byp1) begin
            r1_data = wr_data;
        end
    end

    // Read port 2: same structure as port 1, fully independent.
    always_comb begin
        r2_data = w_mem[r2_addr];
        if (w_byp2) begin
            r2_data = wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_2r1w
//  Description : Self-checking bench for register_file_2r1w. Table-driven
//                vectors, hand-written corner sequences and a randomised
//                phase against a reference array; expectations go through
//                a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_2r1w;

    logic        clk;
    logic        reset;
    logic [4:0]  r1_addr;
    logic [31:0] r1_data;
    logic [4:0]  r2_addr;
    logic [31:0] r2_data;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        reg_write;

    register_file_2r1w #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .r1_addr   (r1_addr),
        .r1_data   (r1_data),
        .r2_addr   (r2_addr),
        .r2_data   (r2_data),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .reg_write (reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
        string       name;
    } exp_t;

    localparam int c_NVEC = 12;

    vec_t        vecs [c_NVEC];
    exp_t        sbq  [$];
    logic [31:0] mdl  [32];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic push_exp(input logic [31:0] e1, input logic [31:0] e2, input string name);
        exp_t e;
        e.e1   = e1;
        e.e2   = e2;
        e.name = name;
        sbq.push_back(e);
    endtask

    // Pop the oldest expectation and compare both read ports against it.
    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sbq.pop_front();
        n_checks++;
        if (r1_data === e.e1) n_pass++;
        else $display("FAIL %s r1: got %h expected %h", e.name, r1_data, e.e1);
        n_checks++;
        if (r2_data === e.e2) n_pass++;
        else $display("FAIL %s r2: got %h expected %h", e.name, r2_data, e.e2);
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        reset     = rst;
        reg_write = we;
        wr_addr   = wa;
        wr_data   = wd;
        r1_addr   = a1;
        r2_addr   = a2;
    endtask

    logic [31:0] p1, p2;

    initial begin
        // Post-edge expectations; identical with or without forwarding.
        vecs[0]  = '{1'b1, 1'b1, 5'd2,  32'd42,        5'd2,  5'd2,  32'd0,         32'd0};
        vecs[1]  = '{1'b0, 1'b1, 5'd2,  32'd42,        5'd2,  5'd2,  32'd42,        32'd42};
        vecs[2]  = '{1'b0, 1'b0, 5'd2,  32'd41,        5'd2,  5'd2,  32'd42,        32'd42};
        vecs[3]  = '{1'b0, 1'b1, 5'd0,  32'hDEADBEEF,  5'd0,  5'd0,  32'd0,         32'd0};
        vecs[4]  = '{1'b0, 1'b1, 5'd5,  32'd7,         5'd5,  5'd5,  32'd7,         32'd7};
        vecs[5]  = '{1'b0, 1'b1, 5'd31, 32'd9,         5'd5,  5'd31, 32'd7,         32'd9};
        vecs[6]  = '{1'b0, 1'b0, 5'd31, 32'd55,        5'd31, 5'd2,  32'd9,         32'd42};
        vecs[7]  = '{1'b0, 1'b1, 5'd3,  32'h12345678,  5'd3,  5'd0,  32'h12345678,  32'd0};
        vecs[8]  = '{1'b0, 1'b0, 5'd1,  32'hFFFFFFFF,  5'd1,  5'd4,  32'd0,         32'd0};
        vecs[9]  = '{1'b0, 1'b1, 5'd1,  32'hFFFFFFFF,  5'd1,  5'd31, 32'hFFFFFFFF,  32'd9};
        vecs[10] = '{1'b0, 1'b1, 5'd16, 32'hA5A5A5A5,  5'd16, 5'd0,  32'hA5A5A5A5,  32'd0};
        vecs[11] = '{1'b0, 1'b0, 5'd16, 32'd0,         5'd16, 5'd1,  32'hA5A5A5A5,  32'hFFFFFFFF};

        // Reset state: outputs zero for arbitrary addresses.
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7);
        edge_sample();
        edge_sample();
        push_exp(32'd0, 32'd0, "reset_state");
        pop_check();

        // Table vectors: drive, queue the expectation, clock, compare.
        for (int i = 0; i < c_NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].a1, vecs[i].a2);
            push_exp(vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));
            edge_sample();
            pop_check();
        end

        // Independent ports: moving r1_addr changes r1_data with no edge.
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31);
        #1;
        push_exp(32'd7, 32'd9, "ports_same_cycle");
        pop_check();
        r1_addr = 5'd31;
        #1;
        push_exp(32'd9, 32'd9, "addr_change_no_edge");
        pop_check();

        // Asynchronous reset between edges, then a write attempt during reset.
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd16);
        #1;
        push_exp(32'h12345678, 32'hA5A5A5A5, "before_async_reset");
        pop_check();
        reset = 1'b1;
        #1;
        push_exp(32'd0, 32'd0, "async_reset_immediate");
        pop_check();
        reg_write = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 32'd77;
        edge_sample();
        reset     = 1'b0;
        reg_write = 1'b0;
        #1;
        push_exp(32'd0, 32'd0, "write_during_reset_dropped");
        pop_check();
        edge_sample();
        push_exp(32'd0, 32'd0, "after_reset_idle_edge");
        pop_check();

        // Read during write on the same address, before and after the edge.
        drive(1'b0, 1'b1, 5'd4, 32'd100, 5'd4, 5'd0);
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        push_exp(32'd100, 32'd0, "rdw_before_edge");
`else
        push_exp(32'd0, 32'd0, "rdw_before_edge");
`endif
        pop_check();
        edge_sample();
        push_exp(32'd100, 32'd0, "rdw_after_edge");
        pop_check();

        // Randomised phase from a clean reset against a reference array.
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        edge_sample();
        reset = 1'b0;
        for (int k = 0; k < 32; k++) mdl[k] = 32'd0;
        for (int n = 0; n < 300; n++) begin
            reg_write = 1'($urandom_range(0, 1));
            wr_addr   = 5'($urandom_range(0, 31));
            wr_data   = $urandom;
            r1_addr   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            r2_addr   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) r1_addr = wr_addr;
            #1;
            p1 = mdl[r1_addr];
            p2 = mdl[r2_addr];
`ifdef REGFILE_WRITE_BYPASS_EN
            if (reg_write && wr_addr != 5'd0 && r1_addr == wr_addr) p1 = wr_data;
            if (reg_write && wr_addr != 5'd0 && r2_addr == wr_addr) p2 = wr_data;
`endif
            push_exp(p1, p2, $sformatf("rand_pre%0d", n));
            pop_check();
            if (reg_write && wr_addr != 5'd0) mdl[wr_addr] = wr_data;
            push_exp(mdl[r1_addr], mdl[r2_addr], $sformatf("rand_post%0d", n));
            edge_sample();
            pop_check();
        end

        if (sbq.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sbq.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
